// File: rtl/inv_lshr_solver_if.sv
// Request/result handshake bundle for inv_lshr_solver.
// The requester uses the master modport and the solver uses the slave modport.
interface inv_lshr_solver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_t;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
  logic [WIDTH-1:0] out_x;

  modport master (
    output in_valid, in_mode, in_s, in_t, out_ready,
    input  in_ready, out_valid, out_sat, out_x
  );

  modport slave (
    input  in_valid, in_mode, in_s, in_t, out_ready,
    output in_ready, out_valid, out_sat, out_x
  );
endinterface

// File: rtl/inv_lshr_solver.sv
// Sequential Skolem solver for logical-shift-right equations (mode 0: s >> x == t, mode 1: x >> s == t).
// Optional result self-check port chk_err is enabled by defining INV_LSHR_SELFCHECK_EN.
module inv_lshr_solver #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_lshr_solver_if.slave     bus
`ifdef INV_LSHR_SELFCHECK_EN
  ,
  output logic                 chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cand;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_sat_r;
  logic [WIDTH-1:0] out_x_r;

  logic             mode_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] t_reg;

  logic             accept;
  logic             hit;
  logic             last;
  logic [WIDTH-1:0] m1_x;
  logic             m1_sat;

  assign accept = bus.in_valid & in_ready_r;

  // Operands are data only: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_reg <= bus.in_mode;
      s_reg    <= bus.in_s;
      t_reg    <= bus.in_t;
    end
  end

  // Shifting left then back right recovers t only if its top s bits are zero;
  // shift amounts >= WIDTH yield 0, which covers the s >= WIDTH case as well.
  always_comb begin
    m1_x   = t_reg << s_reg;
    m1_sat = ((m1_x >> s_reg) == t_reg);
  end

  assign hit  = ((s_reg >> cand) == t_reg);
  assign last = (cand == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sat_r   <= 1'b0;
      out_x_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SEARCH;
            cand       <= '0;
            in_ready_r <= 1'b0;
          end
        end
        SEARCH: begin
          if (mode_reg) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            out_sat_r   <= m1_sat;
            out_x_r     <= m1_sat ? m1_x : '0;
          end else if (hit) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            out_sat_r   <= 1'b1;
            out_x_r     <= WIDTH'(cand);
          end else if (!last) begin
            cand <= cand + CW'(1);
          end else begin
            // Every shift >= WIDTH gives 0, so WIDTH is the smallest such witness.
            state       <= DONE;
            out_valid_r <= 1'b1;
            out_sat_r   <= (t_reg == '0);
            out_x_r     <= (t_reg == '0) ? WIDTH'(WIDTH) : '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_x     = out_x_r;

`ifdef INV_LSHR_SELFCHECK_EN
  logic [WIDTH-1:0] fwd;

  always_comb begin
    fwd = mode_reg ? (out_x_r >> s_reg) : (s_reg >> out_x_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (out_valid_r && out_sat_r && (fwd != t_reg)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/inv_lshr_solver.md
Name: inv_lshr_solver

Overview:
- Sequential, width-parametrised Skolem solver for logical-shift-right equations.
- Mode 0: given s, t, finds the smallest shift amount x with (s >> x) == t.
- Mode 1: given s, t, finds a value x with (x >> s) == t.
- Sits behind the generated fixed-width combinational Skolem functions as the general engine for any WIDTH, with a valid/ready request interface and a registered, held result.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), derived candidate-counter width; not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; one clock only
- in_valid  in  1  request valid
- in_ready  out  1  solver can accept a request
- in_mode  in  1  0 = unknown shift amount, 1 = unknown shifted value
- in_s  in  WIDTH  operand s
- in_t  in  WIDTH  target t
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sat  out  1  1 = a solution exists and out_x is one
- out_x  out  WIDTH  witness value; 0 when out_sat = 0

Behaviour:
- States: IDLE, SEARCH, DONE.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_sat 0, out_x 0, cand 0.
- Ready/valid signals:
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - A request is accepted on an edge with in_valid & in_ready. in_mode, in_s and in_t are registered at that edge.
- IDLE, accept with mode 1: go to DONE at the next edge. Latency is 1 cycle.
  - If s >= WIDTH: sat = (t == 0), x = 0.
  - Otherwise: sat = (top s bits of t all 0), x = sat ? (t << s) truncated to WIDTH : 0.
- IDLE, accept with mode 0: go to SEARCH with cand = 0.
- SEARCH, one candidate per cycle; compare (s_reg >> cand) with t_reg.
  - On a match, go to DONE with sat = 1 and x = cand.
  - On a mismatch with cand < WIDTH-1, increment cand.
  - On a mismatch with cand == WIDTH-1: if t_reg == 0, DONE with sat = 1, x = WIDTH. Otherwise DONE with sat = 0, x = 0.
  - Latency from accept to out_valid is k+1 cycles for a match at k; the maximum is WIDTH.
- DONE:
  - Hold out_sat, out_x and out_valid stable until out_valid & out_ready.
  - On that edge, return to IDLE. A new request is not accepted in the same cycle, so at most one request is in flight.
- Returned x is always the smallest valid shift in mode 0. Shift amounts >= WIDTH are treated as producing 0, and WIDTH fits in WIDTH bits for WIDTH >= 2.
- Input changes while not in IDLE are ignored.
- rst mid-operation: the next edge forces IDLE, drops out_valid and discards the in-flight result.
- rst dominates simultaneous handshakes.

Optional Feature:
- Macro: INV_LSHR_SELFCHECK_EN.
- Defined:
  - Adds output port chk_err, 1 bit, reset 0.
  - In DONE with out_sat = 1, recompute the forward operation: mode 0 uses s_reg >> out_x; mode 1 uses out_x >> s_reg. Treat shift amounts >= WIDTH as producing 0.
  - On mismatch with t_reg, chk_err sets and stays set until rst.
  - No effect on latency or on any other output.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- WIDTH=4, mode 0, s=1100, t=0011 -> out_valid 3 cycles after accept; out_sat=1, out_x=0010.
- WIDTH=4, mode 0, s=1000, t=0000 -> out_valid after 4 cycles; out_sat=1, out_x=0100. Then s=0101, t=0011 -> after 4 cycles out_sat=0, out_x=0000.
- WIDTH=4, mode 1:
  - s=0001, t=0111 -> 1 cycle; out_sat=1, out_x=1110.
  - s=0010, t=0100 -> out_sat=0, out_x=0000.
  - s=0101, t=0000 -> out_sat=1, out_x=0000.
- Backpressure, mode 0, s=0110, t=0110: hold out_ready=0 for 5 cycles -> out_valid, out_sat=1 and out_x=0000 stay stable and in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-search, mode 0, s=1000, t=0001: assert rst one cycle after accept -> out_valid never rises, state IDLE, in_ready=1. A following request solves normally: mode 0, s=1000, t=0001 gives x=0011.
- WIDTH=8 sweep with INV_LSHR_SELFCHECK_EN defined: 1000 random requests compared against a reference model. Required: mode-0 x is minimal, sat matches exhaustive enumeration over x in 0..255, chk_err stays 0.
